clk_div_monitor: RTL

//  Receive-side checker for divided clocks from our clock dividers (e.g. divide-by-7).

---
 rtl/clk_div_monitor.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/clk_div_monitor.sv
// Receive-side checker for a divided clock sampled in the master clock domain.
// Measures period/high/low time, checks the period against EXP_DIV +/- TOL, and flags lock and stuck.
module clk_div_monitor #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned EXP_DIV = 7,
    parameter int unsigned TOL     = 0,
    parameter int unsigned LOCK_N  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_clk_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             meas_valid,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             lock,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PerLo  = CNT_W'(EXP_DIV - TOL);
    localparam logic [CNT_W-1:0] PerHi  = CNT_W'(EXP_DIV + TOL);
    localparam int unsigned      RunW   = $clog2(LOCK_N + 1);
    localparam logic [RunW-1:0]  RunMax = RunW'(LOCK_N);

    if (!((EXP_DIV + TOL < (2 ** CNT_W) - 1) && (EXP_DIV > TOL))) begin : g_param_check
        $error("clk_div_monitor: EXP_DIV/TOL out of range for CNT_W");
    end

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e           state_q, state_d;
    logic             d_q, d_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             meas_valid_q, meas_valid_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [RunW-1:0]  run_q, run_d;
    logic             lock_q, lock_d;
    logic             stuck_q, stuck_d;

    logic rise;
    logic fall;
    logic good;

    always_comb begin
        rise  = div_clk_in & ~d_q;
        fall  = ~div_clk_in & d_q;
        good  = (cnt_q >= PerLo) && (cnt_q <= PerHi);
        d_d   = div_clk_in;
        armed_d = armed_q | rise;
        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        period_d     = period_q;
        high_d       = high_q;
        low_d        = low_q;
        meas_valid_d = 1'b0;
        err_d        = 1'b0;
        run_d        = run_q;
        lock_d       = lock_q;
        stuck_d      = stuck_q;

        if (!en) begin
            state_d = StIdle;
            lock_d  = 1'b0;
            stuck_d = 1'b0;
            run_d   = '0;
        end else if (rise) begin
            stuck_d = 1'b0;
            case (state_q)
                StIdle: state_d = StHigh;
                // Rise without a fall cannot happen for a synchronous input; ignore it.
                StHigh: state_d = StHigh;
                StLow: begin
                    state_d      = StHigh;
                    period_d     = cnt_q;
                    high_d       = h_q;
                    low_d        = cnt_q - h_q;
                    meas_valid_d = 1'b1;
                    if (good) begin
                        run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
                        if (run_d == RunMax) begin
                            lock_d = 1'b1;
                        end
                    end else begin
                        err_d  = 1'b1;
                        run_d  = '0;
                        lock_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if ((cnt_q == CntMax) && !stuck_q && ((state_q != StIdle) || armed_q)) begin
            stuck_d = 1'b1;
            lock_d  = 1'b0;
            run_d   = '0;
            state_d = StIdle;
        end else if (fall && (state_q == StHigh)) begin
            state_d = StLow;
            h_d     = cnt_q;
        end
    end

    // clr_err is sampled on the same edge that launches an err pulse, so both can coincide.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = err_d ? 8'd1 : 8'd0;
        end else if (err_d && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            d_q          <= 1'b0;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            h_q          <= '0;
            period_q     <= '0;
            high_q       <= '0;
            low_q        <= '0;
            meas_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            run_q        <= '0;
            lock_q       <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            h_q          <= h_d;
            period_q     <= period_d;
            high_q       <= high_d;
            low_q        <= low_d;
            meas_valid_q <= meas_valid_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            run_q        <= run_d;
            lock_q       <= lock_d;
            stuck_q      <= stuck_d;
        end
    end

    assign period     = period_q;
    assign high_cnt   = high_q;
    assign low_cnt    = low_q;
    assign meas_valid = meas_valid_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;
    assign lock       = lock_q;
    assign stuck      = stuck_q;

endmodule
